// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Issue/retire controller for the iterative RV32M multiplier. It accepts one
// MUL/MULH/MULHSU/MULHU request at a time, launches the external multiplier,
// waits for its completion pulse, selects the low or high product word and
// returns the tagged result to writeback. At most one operation is in flight.
//
// Optional build macro:
//   MUL_SEQ_FUSE_EN  one-entry result cache. A request whose operands (and,
//                    except for MUL, signedness) match the last completed
//                    multiplication is answered from the cache with no launch.
//                    When the macro is undefined every request launches.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous active-high reset
//   req_valid / req_ready    request handshake from ALU dispatch
//   req_op                   funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1 / req_rs2        multiplicand / multiplier
//   req_tag                  opaque destination tag
//   flush                    kill the in-flight operation
//   mul_start                one-cycle launch pulse to the multiplier
//   mul_multiplicand/_multiplier   operands to the multiplier
//   mul_signed_multiplicand/_multiplier  operand signedness
//   mul_product_low/_high    product words from the multiplier
//   mul_done                 one-cycle completion pulse from the multiplier
//   rsp_valid / rsp_ready    result handshake to writeback
//   rsp_data / rsp_tag       result word and its tag
//   busy                     controller is not idle
// -----------------------------------------------------------------------------

package core_config_pkg;
    localparam int XLEN = 32;
endpackage

module mul_sequencer #(
    parameter int XLEN  = core_config_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             mul_start,
    output logic [XLEN-1:0]  mul_multiplicand,
    output logic [XLEN-1:0]  mul_multiplier,
    output logic             mul_signed_multiplicand,
    output logic             mul_signed_multiplier,
    input  logic [XLEN-1:0]  mul_product_low,
    input  logic [XLEN-1:0]  mul_product_high,
    input  logic             mul_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // {rs1 signed, rs2 signed} for each opcode.
    function automatic logic [1:0] op_signs(input logic [1:0] op);
        logic [1:0] s;
        case (op)
            OP_MUL:    s = 2'b11;
            OP_MULH:   s = 2'b11;
            OP_MULHSU: s = 2'b10;
            OP_MULHU:  s = 2'b00;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

    state_e             state_q;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               drop_q;
    logic               req_ready_q;
    logic               mul_start_q;
    logic [XLEN-1:0]    mul_multiplicand_q;
    logic [XLEN-1:0]    mul_multiplier_q;
    logic               mul_signed_multiplicand_q;
    logic               mul_signed_multiplier_q;
    logic               rsp_valid_q;
    logic [XLEN-1:0]    rsp_data_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               busy_q;

    logic [XLEN-1:0]    rsp_data_d;
    logic [1:0]         sign_pair_d;

`ifdef MUL_SEQ_FUSE_EN
    logic               cache_valid_q;
    logic [XLEN-1:0]    cache_rs1_q;
    logic [XLEN-1:0]    cache_rs2_q;
    logic [1:0]         cache_signs_q;
    logic [XLEN-1:0]    cache_low_q;
    logic [XLEN-1:0]    cache_high_q;
    logic               hit_d;
    logic [XLEN-1:0]    hit_data_d;
`endif

    // Product word selection and signedness decode for the incoming request.
    always_comb begin
        sign_pair_d = op_signs(req_op);
        if (op_q == OP_MUL) begin
            rsp_data_d = mul_product_low;
        end else begin
            rsp_data_d = mul_product_high;
        end
    end

`ifdef MUL_SEQ_FUSE_EN
    // Cache lookup: the low word of MUL is the same for every signedness,
    // so MUL only needs the operands to match.
    always_comb begin
        hit_d      = 1'b0;
        hit_data_d = cache_high_q;
        if (cache_valid_q && (req_rs1 == cache_rs1_q) && (req_rs2 == cache_rs2_q)) begin
            if (req_op == OP_MUL) begin
                hit_d      = 1'b1;
                hit_data_d = cache_low_q;
            end else if (sign_pair_d == cache_signs_q) begin
                hit_d      = 1'b1;
                hit_data_d = cache_high_q;
            end else begin
                hit_d      = 1'b0;
                hit_data_d = cache_high_q;
            end
        end else begin
            hit_d      = 1'b0;
            hit_data_d = cache_high_q;
        end
    end
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                   <= ST_IDLE;
            op_q                      <= 2'b00;
            tag_q                     <= {TAG_W{1'b0}};
            drop_q                    <= 1'b0;
            req_ready_q               <= 1'b1;
            mul_start_q               <= 1'b0;
            mul_multiplicand_q        <= {XLEN{1'b0}};
            mul_multiplier_q          <= {XLEN{1'b0}};
            mul_signed_multiplicand_q <= 1'b0;
            mul_signed_multiplier_q   <= 1'b0;
            rsp_valid_q               <= 1'b0;
            rsp_data_q                <= {XLEN{1'b0}};
            rsp_tag_q                 <= {TAG_W{1'b0}};
            busy_q                    <= 1'b0;
`ifdef MUL_SEQ_FUSE_EN
            cache_valid_q             <= 1'b0;
            cache_rs1_q               <= {XLEN{1'b0}};
            cache_rs2_q               <= {XLEN{1'b0}};
            cache_signs_q             <= 2'b00;
            cache_low_q               <= {XLEN{1'b0}};
            cache_high_q              <= {XLEN{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drop_q      <= 1'b0;
                    mul_start_q <= 1'b0;
                    // A request alongside flush is not taken.
                    if (req_valid && !flush) begin
                        op_q                      <= req_op;
                        tag_q                     <= req_tag;
                        mul_multiplicand_q        <= req_rs1;
                        mul_multiplier_q          <= req_rs2;
                        mul_signed_multiplicand_q <= sign_pair_d[1];
                        mul_signed_multiplier_q   <= sign_pair_d[0];
                        req_ready_q               <= 1'b0;
                        busy_q                    <= 1'b1;
`ifdef MUL_SEQ_FUSE_EN
                        if (hit_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= hit_data_d;
                            rsp_tag_q   <= req_tag;
                            state_q     <= ST_RESP;
                        end else begin
                            mul_start_q <= 1'b1;
                            state_q     <= ST_LAUNCH;
                        end
`else
                        mul_start_q <= 1'b1;
                        state_q     <= ST_LAUNCH;
`endif
                    end else begin
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                ST_LAUNCH: begin
                    mul_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (mul_done) begin
`ifdef MUL_SEQ_FUSE_EN
                        // Dropped results are still correct, so they are cached too.
                        cache_valid_q <= 1'b1;
                        cache_rs1_q   <= mul_multiplicand_q;
                        cache_rs2_q   <= mul_multiplier_q;
                        cache_signs_q <= {mul_signed_multiplicand_q, mul_signed_multiplier_q};
                        cache_low_q   <= mul_product_low;
                        cache_high_q  <= mul_product_high;
`endif
                        // A flush coinciding with done also kills the result.
                        if (drop_q || flush) begin
                            drop_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rsp_data_d;
                            rsp_tag_q   <= tag_q;
                            state_q     <= ST_RESP;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end

                ST_RESP: begin
                    if (flush || rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        drop_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    drop_q      <= 1'b0;
                    mul_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready               = req_ready_q;
    assign mul_start               = mul_start_q;
    assign mul_multiplicand        = mul_multiplicand_q;
    assign mul_multiplier          = mul_multiplier_q;
    assign mul_signed_multiplicand = mul_signed_multiplicand_q;
    assign mul_signed_multiplier   = mul_signed_multiplier_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_data                = rsp_data_q;
    assign rsp_tag                 = rsp_tag_q;
    assign busy                    = busy_q;

endmodule
